sif_cmd_bridge: RTL
===================

Name: sif_cmd_bridge

Overview:
Parametrised successor to the single-port SIF DUT. It accepts XA-side write/read strobes (xa_wr_s / xa_rd_s, same encoding as the lib::E_Operation opcodes) into a command FIFO of configurable depth. It replays the commands onto a WA-side request/acknowledge bus with a per-transaction timeout, and returns read data to the XA side. Illegal opcodes, FIFO overflow and WA timeouts are flagged for the XA/WA monitors.

Parameters:
DATA_W, 32, data width on both sides
ADDR_W, 8, address width on both sides
DEPTH, 4, command FIFO entries; power of two, >= 2
TIMEOUT, 16, maximum wa_req cycles without wa_ack before abort; 0 disables the timeout

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
xa_wr_s  in  1  write strobe
xa_rd_s  in  1  read strobe
xa_addr  in  ADDR_W  command address
xa_wdata  in  DATA_W  write data
err_clr  in  1  clears sticky errors and the drop counter
xa_full  out  1  FIFO full
xa_rd_valid  out  1  one-cycle read-return pulse
xa_rd_data  out  DATA_W  read-return data
xa_err_illegal  out  1  sticky; wr and rd strobes seen together
xa_err_timeout  out  1  sticky; a WA transaction timed out
xa_drop_cnt  out  8  saturating count of dropped strobes
wa_req  out  1  WA request
wa_we  out  1  1 = write, 0 = read; valid while wa_req
wa_addr  out  ADDR_W  valid while wa_req
wa_wdata  out  DATA_W  valid while wa_req
wa_ack  in  1  WA completion; sampled only while wa_req=1
wa_rdata  in  DATA_W  read data, sampled with wa_ack

Behaviour:
- Reset: all outputs 0, FIFO emptied, FSM in IDLE, timeout counter 0. A reset asserted mid-transaction drops wa_req the following cycle, produces no xa_rd_valid, and discards all queued commands.
- Opcode decode per cycle, from {xa_wr_s, xa_rd_s}:
  - 10: push write
  - 01: push read
  - 00: idle
  - 11: ILLEGAL; no push, xa_err_illegal set
- Push: the entry {we, addr, wdata} is written at the sampling edge when count < DEPTH.
- xa_full = (count == DEPTH), decoded from registered count. There is no bypass: a strobe while full is dropped even if a pop occurs in the same cycle.
- A dropped strobe increments xa_drop_cnt, which saturates at 255. An ILLEGAL opcode while full counts as illegal only.
- FIFO is circular with pointers of log2(DEPTH)+1 bits; wrap-around must be transparent. Simultaneous push and pop when not full leaves count unchanged.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head into the WA output registers, go to REQ.
  - REQ: wa_req=1; outputs held stable.
    - wa_ack=1: go to DONE; if a read, capture wa_rdata.
    - Timeout counter reaches TIMEOUT-1 with no ack (TIMEOUT>0): go to DONE with abort flag set.
  - DONE: wa_req=0 and FSM returns to IDLE next cycle. For a read, xa_rd_valid=1 for this single cycle with the captured data (0 on abort). An abort sets xa_err_timeout.
- Latency: strobe sampled at end of cycle 0 with FIFO empty and FSM idle → pop at end of cycle 1 → wa_req high in cycle 2. Ack in cycle n → xa_rd_valid in cycle n+1. Back-to-back commands have a minimum WA spacing of one DONE plus one IDLE cycle.
- Timeout counter clears on entering REQ. It counts REQ cycles, so the abort occurs after exactly TIMEOUT cycles of wa_req.
- wa_ack outside REQ is ignored.
- err_clr clears xa_err_illegal, xa_err_timeout and xa_drop_cnt. If a new error or drop occurs in the same cycle, set/increment wins: the flag stays 1 and the counter becomes 1.
- Commands complete in FIFO order; read returns follow command order.

Test Plan:
1. Reset, then WRITE addr 0x10 data 0xDEADBEEF; ack in the 2nd REQ cycle → wa_req high in cycle 2 with wa_we=1, addr 0x10, wdata 0xDEADBEEF; wa_req low after ack; no xa_rd_valid.
2. READ addr 0x22; WA returns 0x12345678 with ack → xa_rd_valid pulses once, the cycle after ack, with 0x12345678.
3. DEPTH=4, wa_ack held 0 with TIMEOUT=0; issue 6 writes → xa_full after the 5th strobe (one command popped, 4 queued), 1 strobe dropped, xa_drop_cnt=1. Then release ack → 5 WA writes in order with wrap-around intact.
4. Assert xa_wr_s=xa_rd_s=1 for one cycle → no WA activity, xa_err_illegal=1. Pulse err_clr → flag 0. Assert err_clr together with another illegal opcode → flag stays 1.
5. TIMEOUT=16, READ with no ack → wa_req high exactly 16 cycles, then xa_rd_valid with data 0 and xa_err_timeout=1. The next queued command then issues normally.
6. Assert rst while in REQ with 2 commands queued → wa_req 0 next cycle, FIFO empty, no xa_rd_valid, all sticky flags 0.

Source files
------------

// File: rtl/sif_cmd_bridge.sv
// XA-to-WA command bridge: strobes are queued in a circular FIFO, replayed as WA
// request/acknowledge transactions with an optional timeout, and read data is returned.
module sif_cmd_bridge #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              xa_wr_s,
    input  logic              xa_rd_s,
    input  logic [ADDR_W-1:0] xa_addr,
    input  logic [DATA_W-1:0] xa_wdata,
    input  logic              err_clr,
    output logic              xa_full,
    output logic              xa_rd_valid,
    output logic [DATA_W-1:0] xa_rd_data,
    output logic              xa_err_illegal,
    output logic              xa_err_timeout,
    output logic [7:0]        xa_drop_cnt,
    output logic              wa_req,
    output logic              wa_we,
    output logic [ADDR_W-1:0] wa_addr,
    output logic [DATA_W-1:0] wa_wdata,
    input  logic              wa_ack,
    input  logic [DATA_W-1:0] wa_rdata
);
    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;
    localparam int ENT_W = 1 + ADDR_W + DATA_W;
    localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [PTR_W-1:0] FULL_CNT = PTR_W'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ENT_W-1:0]    r_mem [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic [TO_W-1:0]     r_to_cnt;
    logic                r_err_illegal;
    logic                r_err_timeout;
    logic [7:0]          r_drop_cnt;

    logic                w_op_wr;
    logic                w_op_rd;
    logic                w_op_ill;
    logic [PTR_W-1:0]    w_count;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_drop;
    logic                w_pop;
    logic                w_ack_take;
    logic                w_abort;
    logic [ENT_W-1:0]    w_head;

    assign w_op_wr  = xa_wr_s & ~xa_rd_s;
    assign w_op_rd  = ~xa_wr_s & xa_rd_s;
    assign w_op_ill = xa_wr_s & xa_rd_s;
    assign w_count  = r_wr_ptr - r_rd_ptr;
    assign w_full   = (w_count == FULL_CNT);
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    // Full is taken from the registered count only, so a same-cycle pop never admits a strobe.
    assign w_push   = (w_op_wr | w_op_rd) & ~w_full;
    assign w_drop   = (w_op_wr | w_op_rd) & w_full;
    assign w_head   = r_mem[r_rd_ptr[AW-1:0]];

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_ack_take  = 1'b0;
        w_abort     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (wa_ack) begin
                    w_ack_take  = 1'b1;
                    w_state_nxt = S_DONE;
                end else if ((TIMEOUT > 0) && (r_to_cnt == TO_LAST)) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Storage needs no reset: entries are only ever read between the pointers.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {w_op_wr, xa_addr, xa_wdata};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_rdata       <= '0;
            r_to_cnt      <= '0;
            r_err_illegal <= 1'b0;
            r_err_timeout <= 1'b0;
            r_drop_cnt    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) begin
                r_rd_ptr                  <= r_rd_ptr + 1'b1;
                {r_we, r_addr, r_wdata}   <= w_head;
                r_to_cnt                  <= '0;
            end else if (r_state == S_REQ) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (w_ack_take)   r_rdata <= r_we ? '0 : wa_rdata;
            else if (w_abort) r_rdata <= '0;
            // A new event in the clearing cycle takes precedence over the clear.
            r_err_illegal <= w_op_ill | (r_err_illegal & ~err_clr);
            r_err_timeout <= w_abort  | (r_err_timeout & ~err_clr);
            if (err_clr)                             r_drop_cnt <= {7'd0, w_drop};
            else if (w_drop && r_drop_cnt != 8'hFF)  r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign xa_full        = w_full;
    assign xa_rd_valid    = (r_state == S_DONE) & ~r_we;
    assign xa_rd_data     = xa_rd_valid ? r_rdata : '0;
    assign xa_err_illegal = r_err_illegal;
    assign xa_err_timeout = r_err_timeout;
    assign xa_drop_cnt    = r_drop_cnt;
    assign wa_req         = (r_state == S_REQ);
    assign wa_we          = r_we;
    assign wa_addr        = r_addr;
    assign wa_wdata       = r_wdata;
endmodule
